free_list: RTL
==============

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 The block SHALL use `clock` (input, 1 bit) as its rising-edge clock; all state updates SHALL occur on the rising edge of `clock`.
REQ-002 The block SHALL use `reset` (input, 1 bit) as a synchronous, active-high reset.
REQ-003 `id_dispatch_num`  input  2  number of free PRs consumed by rename this cycle; value 3 SHALL be treated as 2.
REQ-004 `rob_retire_num`  input  2  number of told tags returned by retirement this cycle; value 3 SHALL be treated as 2.
REQ-005 `rob_told0`  input  7  first released physical register tag; pushed first.
REQ-006 `rob_told1`  input  7  second released physical register tag; pushed second.
REQ-007 `rob_recover`  input  1  mispredict recovery at retire; all in-flight allocations are squashed.
REQ-008 `fl_pr0`  output  7  tag at the head slot.
REQ-009 `fl_pr1`  output  7  tag at slot (head+1) mod 96.
REQ-010 `fl_free_num`  output  2  min(count, 2): how many of `fl_pr0`/`fl_pr1` are valid.
REQ-011 `fl_count`  output  7  current number of free entries, range 0..96.
REQ-012 `fl_error`  output  1  single-cycle pulse on an illegal request, as defined in REQ-018 and REQ-019.

Function
REQ-013 Storage SHALL be a circular buffer of 96 entries, each 7 bits wide, with head, tail and count registers; head and tail SHALL range 0..95 and wrap from 95 to 0.
REQ-014 `fl_pr0`, `fl_pr1`, `fl_free_num` and `fl_count` SHALL be driven from registered state only; there is no same-cycle bypass from push to pop.
REQ-015 The effective pop count `pop` SHALL be min(`id_dispatch_num`, count, 2); head SHALL advance by `pop` mod 96.
REQ-016 The effective push count `push` SHALL be min(`rob_retire_num`, 2); `rob_told0` SHALL be written at tail and `rob_told1` at (tail+1) mod 96; tail SHALL advance by `push` mod 96.
REQ-017 Next count SHALL equal count + push - pop; simultaneous push and pop in the same cycle are both honoured.
REQ-018 When `id_dispatch_num` exceeds count, `fl_error` SHALL pulse for one cycle and only `pop` entries SHALL be consumed.
REQ-019 When count + push - pop exceeds 96, `fl_error` SHALL pulse for one cycle, the excess push SHALL be dropped, and count SHALL saturate at 96.
REQ-020 When count is 0, a push SHALL become visible on `fl_pr0` only on the following cycle.
REQ-021 When `rob_recover`=1, pushes from the same cycle SHALL be written first; then head SHALL be set to next_tail and count to 96, and that cycle's dispatch pop SHALL be ignored.
- Rationale: popped and unretired tags still sit in slots tail..head-1, in FIFO order.
REQ-022 Pointer arithmetic SHALL handle wrap when head or tail is 95 and the step is 2 (95 -> 1).

Reset
REQ-023 When `reset`=1, slot i SHALL be loaded with 32+i for i=0..95, and head, tail and count SHALL be set to 0, 0 and 96.
REQ-024 After reset, outputs SHALL be `fl_pr0`=32, `fl_pr1`=33, `fl_free_num`=2, `fl_count`=96, `fl_error`=0.
REQ-025 `reset` SHALL take priority over all other inputs in the same cycle, including `rob_recover`; in-progress activity SHALL be discarded.

Verification
REQ-026 Reset, then `id_dispatch_num`=2 for one cycle -> `fl_pr0`=34, `fl_pr1`=35, `fl_count`=94.
REQ-027 Reset, 48 cycles of `id_dispatch_num`=2 -> `fl_count`=0, `fl_free_num`=0; one more request with `id_dispatch_num`=1 -> `fl_error`=1, count stays 0.
REQ-028 From count=0, `rob_retire_num`=2 with told 5 and 7 while `id_dispatch_num`=2 -> no pop that cycle; next cycle `fl_pr0`=5, `fl_pr1`=7, `fl_count`=2.
REQ-029 From count=96, `rob_retire_num`=1 -> `fl_error`=1 and `fl_count` remains 96.
REQ-030 Reset, dispatch 10 entries (32..41), retire 4 entries (told 1..4), then `rob_recover`=1 -> `fl_count`=96 and `fl_pr0`=36, the first squashed allocation.
REQ-031 Drive head to 95 via dispatch and retire traffic, then `id_dispatch_num`=2 -> head wraps to 1; `fl_pr1` SHALL be read from slot 0.

Source files
------------

// File: rtl/free_list.sv
// Physical-register free list for rename: a 96-entry circular FIFO of 7-bit tags,
// popped by dispatch (up to 2/cycle) and refilled by retirement (up to 2/cycle).
module free_list (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] id_dispatch_num,
  input  logic [1:0] rob_retire_num,
  input  logic [6:0] rob_told0,
  input  logic [6:0] rob_told1,
  input  logic       rob_recover,
  output logic [6:0] fl_pr0,
  output logic [6:0] fl_pr1,
  output logic [1:0] fl_free_num,
  output logic [6:0] fl_count,
  output logic       fl_error
);

  localparam logic [6:0] DEPTH = 7'd96;

  logic [6:0] r_mem [0:95];
  logic [6:0] r_head;
  logic [6:0] r_tail;
  logic [6:0] r_count;
  logic       r_error;

  logic [1:0] w_disp;
  logic [1:0] w_ret;
  logic [1:0] w_pop;
  logic [1:0] w_push;
  logic [6:0] w_room;
  logic       w_disp_err;
  logic       w_over_err;
  logic [6:0] w_head_p1;
  logic [6:0] w_tail_p1;
  logic [6:0] w_next_tail;
  logic [6:0] w_next_head;

  // Modulo-96 pointer step of 0..2; a single conditional subtract covers 95 -> 1.
  function automatic logic [6:0] ptr_add(input logic [6:0] p, input logic [1:0] s);
    logic [7:0] sum;
    sum = {1'b0, p} + {6'd0, s};
    if (sum >= {1'b0, DEPTH}) begin
      sum = sum - {1'b0, DEPTH};
    end else begin
      sum = sum;
    end
    return sum[6:0];
  endfunction

  // Effective pop/push counts and error detection for this cycle.
  always_comb begin
    w_disp     = (id_dispatch_num == 2'd3) ? 2'd2 : id_dispatch_num;
    w_ret      = (rob_retire_num  == 2'd3) ? 2'd2 : rob_retire_num;
    w_pop      = 2'd0;
    w_disp_err = 1'b0;
    if (rob_recover) begin
      w_pop      = 2'd0;
      w_disp_err = 1'b0;
    end else if ({5'd0, w_disp} > r_count) begin
      // only reachable with count <= 1, so the low bits are the whole count
      w_pop      = r_count[1:0];
      w_disp_err = 1'b1;
    end else begin
      w_pop      = w_disp;
      w_disp_err = 1'b0;
    end
    w_room     = DEPTH - r_count + {5'd0, w_pop};
    w_push     = 2'd0;
    w_over_err = 1'b0;
    if ({5'd0, w_ret} > w_room) begin
      w_push     = w_room[1:0];
      w_over_err = 1'b1;
    end else begin
      w_push     = w_ret;
      w_over_err = 1'b0;
    end
    w_head_p1   = ptr_add(r_head, 2'd1);
    w_tail_p1   = ptr_add(r_tail, 2'd1);
    w_next_tail = ptr_add(r_tail, w_push);
    w_next_head = ptr_add(r_head, w_pop);
  end

  // Storage, pointers and count; recovery reclaims every slot from next_tail around to tail.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 96; i++) begin
        r_mem[i] <= 7'(i + 32);
      end
      r_head  <= 7'd0;
      r_tail  <= 7'd0;
      r_count <= DEPTH;
      r_error <= 1'b0;
    end else begin
      if (w_push != 2'd0) begin
        r_mem[r_tail] <= rob_told0;
      end
      if (w_push == 2'd2) begin
        r_mem[w_tail_p1] <= rob_told1;
      end
      r_tail  <= w_next_tail;
      r_error <= w_disp_err | w_over_err;
      if (rob_recover) begin
        r_head  <= w_next_tail;
        r_count <= DEPTH;
      end else begin
        r_head  <= w_next_head;
        r_count <= r_count + {5'd0, w_push} - {5'd0, w_pop};
      end
    end
  end

  assign fl_pr0      = r_mem[r_head];
  assign fl_pr1      = r_mem[w_head_p1];
  assign fl_free_num = (r_count >= 7'd2) ? 2'd2 : r_count[1:0];
  assign fl_count    = r_count;
  assign fl_error    = r_error;

endmodule
